banco_reg_multi: RTL and testbench



---
 rtl/banco_reg_pkg.sv | 11 +
 rtl/banco_reg_clr_seq.sv | 38 +++
 rtl/banco_reg_multi.sv | 85 ++++++++
 tb/tb_banco_reg_multi.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/banco_reg_pkg.sv
// Shared constants for the register bank: sequencer state encoding and the
// default word/address widths also used by the decoder and ALU.
package banco_reg_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_ADDR_W = 2;

endpackage

// File: rtl/banco_reg_clr_seq.sv
// Post-reset clear sequencer: walks every register address once, owning the
// bank's write port until the walk completes.
module banco_reg_clr_seq
  import banco_reg_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  // DEPTH-1 is all ones because DEPTH is a power of two
  localparam logic [ADDR_W-1:0] LAST = '1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else if (state == ST_CLEAR) begin
      if (clr_ptr == LAST) begin
        state <= ST_IDLE;
      end else begin
        clr_ptr <= clr_ptr + 1'b1;
      end
    end
  end

  assign busy     = (state == ST_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = clr_ptr;

endmodule

// File: rtl/banco_reg_multi.sv
// Parametrised 2-read/1-write register bank with post-reset clear sequencer.
// Optional same-cycle write-to-read bypass: define BANCO_REG_BYPASS_EN.
module banco_reg_multi
  import banco_reg_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int ZERO_R0 = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Read1,
  input  logic [ADDR_W-1:0] Read2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic              RegWrite,
  output logic [WIDTH-1:0]  Data1,
  output logic [WIDTH-1:0]  Data2,
  output logic              busy,
  output logic              wr_rej
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0]  rf [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_drop_r0;
  logic              wr_acc;
  logic              byp1;
  logic              byp2;

  banco_reg_clr_seq #(.ADDR_W(ADDR_W)) u_clr_seq (
    .clock    (clock),
    .reset    (reset),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // R0 writes vanish silently; they are not reported through wr_rej
  assign wr_drop_r0 = (ZERO_R0 != 0) && (WriteReg == '0);
  assign wr_acc     = RegWrite && !busy && !wr_drop_r0;

  always_ff @(posedge clock) begin
    if (clr_we) begin
      rf[clr_addr] <= '0;
    end else if (wr_acc && !reset) begin
      rf[WriteReg] <= WriteData;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_rej <= 1'b0;
    end else begin
      wr_rej <= RegWrite && busy;
    end
  end

`ifdef BANCO_REG_BYPASS_EN
  assign byp1 = wr_acc && (WriteReg == Read1);
  assign byp2 = wr_acc && (WriteReg == Read2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] rd_port(
    input logic [ADDR_W-1:0] ra,
    input logic [WIDTH-1:0]  stored,
    input logic              blk,
    input logic              byp,
    input logic [WIDTH-1:0]  wd
  );
    if (blk || ((ZERO_R0 != 0) && (ra == '0))) begin
      return '0;
    end
    return byp ? wd : stored;
  endfunction

  assign Data1 = rd_port(Read1, rf[Read1], busy, byp1, WriteData);
  assign Data2 = rd_port(Read2, rf[Read2], busy, byp2, WriteData);

endmodule

// File: tb/tb_banco_reg_multi.sv
// Bench for banco_reg_multi: three configurations share one stimulus stream and
// are compared every cycle against an array-based model of the bank.
module tb_banco_reg_multi;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  ra1 = '0, ra2 = '0, wa = '0;
  logic [15:0] wd = '0;
  logic        we = 1'b0;

  logic [7:0]  a_d1, a_d2, b_d1, b_d2;
  logic [15:0] c_d1, c_d2;
  logic        a_busy, b_busy, c_busy, a_rej, b_rej, c_rej;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clock = ~clock;

  banco_reg_multi #(.WIDTH(8), .ADDR_W(2), .ZERO_R0(1)) dut_a (
    .clock(clock), .reset(reset), .Read1(ra1[1:0]), .Read2(ra2[1:0]),
    .WriteReg(wa[1:0]), .WriteData(wd[7:0]), .RegWrite(we),
    .Data1(a_d1), .Data2(a_d2), .busy(a_busy), .wr_rej(a_rej));

  banco_reg_multi #(.WIDTH(8), .ADDR_W(2), .ZERO_R0(0)) dut_b (
    .clock(clock), .reset(reset), .Read1(ra1[1:0]), .Read2(ra2[1:0]),
    .WriteReg(wa[1:0]), .WriteData(wd[7:0]), .RegWrite(we),
    .Data1(b_d1), .Data2(b_d2), .busy(b_busy), .wr_rej(b_rej));

  banco_reg_multi #(.WIDTH(16), .ADDR_W(5), .ZERO_R0(1)) dut_c (
    .clock(clock), .reset(reset), .Read1(ra1), .Read2(ra2),
    .WriteReg(wa), .WriteData(wd), .RegWrite(we),
    .Data1(c_d1), .Data2(c_d2), .busy(c_busy), .wr_rej(c_rej));

  // Reference model: plain storage array, count of clear cycles still to run
  int unsigned depth [3] = '{4, 4, 32};
  int unsigned mask  [3] = '{32'hFF, 32'hFF, 32'hFFFF};
  bit          zr    [3] = '{1'b1, 1'b0, 1'b1};
  int unsigned mem   [3][32];
  int          clr_left [3];
  bit          rej   [3];
  bit          known = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned exp_read(input int d, input int unsigned ra_in);
    int unsigned ra, wad;
    ra  = ra_in % depth[d];
    wad = 32'(wa) % depth[d];
    if (clr_left[d] > 0) return 0;
    if (zr[d] && ra == 0) return 0;
`ifdef BANCO_REG_BYPASS_EN
    if (we && wad == ra) return 32'(wd) & mask[d];
`endif
    return mem[d][ra];
  endfunction

  task automatic check_all();
    logic [15:0] o1 [3];
    logic [15:0] o2 [3];
    logic        ob [3];
    logic        orj [3];
    o1  = '{16'(a_d1), 16'(b_d1), c_d1};
    o2  = '{16'(a_d2), 16'(b_d2), c_d2};
    ob  = '{a_busy, b_busy, c_busy};
    orj = '{a_rej, b_rej, c_rej};
    for (int d = 0; d < 3; d++) begin
      check_val($sformatf("dut%0d.Data1", d), 32'(o1[d]), exp_read(d, 32'(ra1)));
      check_val($sformatf("dut%0d.Data2", d), 32'(o2[d]), exp_read(d, 32'(ra2)));
      check_val($sformatf("dut%0d.busy", d), 32'(ob[d]), 32'(clr_left[d] > 0));
      check_val($sformatf("dut%0d.wr_rej", d), 32'(orj[d]), 32'(rej[d]));
    end
  endtask

  task automatic update_model();
    int unsigned wad;
    for (int d = 0; d < 3; d++) begin
      wad = 32'(wa) % depth[d];
      if (reset) begin
        clr_left[d] = int'(depth[d]);
        rej[d] = 1'b0;
        for (int i = 0; i < 32; i++) mem[d][i] = 0;
      end else if (clr_left[d] > 0) begin
        rej[d] = we;
        clr_left[d]--;
      end else begin
        rej[d] = 1'b0;
        if (we && !(zr[d] && wad == 0)) mem[d][wad] = 32'(wd) & mask[d];
      end
    end
    if (reset) known = 1'b1;
  endtask

  task automatic drive(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] w_a, input logic [15:0] w_d, input logic w_e);
    @(negedge clock);
    reset = r; ra1 = a1; ra2 = a2; wa = w_a; wd = w_d; we = w_e;
    #1;
    if (known) check_all();
    @(posedge clock);
    update_model();
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 2, 0, 0, 0);
    // busy window, write attempted on the second busy cycle
    drive(0, 1, 2, 0, 0, 0);
    drive(0, 3, 3, 3, 16'h3C, 1);
    drive(0, 3, 2, 0, 0, 0);
    drive(0, 3, 1, 0, 0, 0);
    drive(0, 3, 0, 0, 0, 0);
    drive(0, 3, 2, 0, 0, 0);
    // write A5 to R2 and read it back
    drive(0, 2, 2, 2, 16'hA5, 1);
    #1 check_val("a5_readback", 32'(a_d1), 32'hA5);
    drive(0, 2, 3, 0, 0, 0);
    // reset in the middle of a clear
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 2, 2, 0, 0, 0);
    drive(0, 2, 2, 0, 0, 0);
    drive(1, 2, 2, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 5'(i), 5'(i + 1), 0, 0, 0);
    // write FF to R0
    drive(0, 0, 0, 0, 16'hFF, 1);
    drive(0, 0, 0, 0, 0, 0);
    #1 check_val("r0_zero_a", 32'(a_d1), 32'h0);
    check_val("r0_kept_b", 32'(b_d1), 32'hFF);
    // same-cycle read of a register being written
    drive(0, 1, 1, 1, 16'h11, 1);
    drive(0, 1, 1, 1, 16'h22, 1);
    drive(0, 1, 1, 0, 0, 0);
    // let the 32-entry bank finish clearing, then use R31
    for (int i = 0; i < 40; i++) drive(0, 5'(i), 5'(31 - i), 0, 0, 0);
    drive(0, 31, 31, 31, 16'hBEEF, 1);
    #1 check_val("beef_p1", 32'(c_d1), 32'hBEEF);
    check_val("beef_p2", 32'(c_d2), 32'hBEEF);
    drive(0, 31, 31, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 299) == 0), 5'($urandom), 5'($urandom), 5'($urandom),
            16'($urandom), 1'($urandom));
    end
    drive(0, 0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
